// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command sequencer: opcode decode, MODE/GPIO registers, soft reset, read responses
//
// Ports:
//   sys_clk   in   system clock, all logic on posedge
//   rst       in   asynchronous active-high reset
//   rx_valid  in   one-cycle strobe, rx_byte holds a complete received byte
//   rx_byte   in   received byte (command or data/dummy)
//   gpio_in   in   sampled GPIO inputs, captured on a GPIO read command
//   tx_byte   out  response byte for the shifter
//   tx_load   out  one-cycle strobe: shifter loads tx_byte
//   mode      out  MODE register
//   gpio_out  out  GPIO output register
//   soft_rst  out  soft-reset pulse to the rest of the design
//   busy      out  high while a transaction or soft-reset pulse is in progress
//   err       out  sticky error flag, cleared by a STATUS read or soft reset

module spi_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES   = 1023,
    parameter int unsigned RST_PULSE_CYCLES = 4,
    parameter logic [7:0]  MODE_RESET       = 8'h00,
    parameter logic [7:0]  GPIO_RESET       = 8'h00
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [7:0] gpio_in,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [7:0] mode,
    output logic [7:0] gpio_out,
    output logic       soft_rst,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WDATA  = 2'd1,
        RDUMMY = 2'd2,
        SRST   = 2'd3
    } state_t;

    localparam logic [3:0] OP_RESET   = 4'h0;
    localparam logic [3:0] OP_MODE_WR = 4'h1;
    localparam logic [3:0] OP_MODE_RD = 4'h2;
    localparam logic [3:0] OP_GPIO_WR = 4'hB;
    localparam logic [3:0] OP_GPIO_RD = 4'hC;
    localparam logic [3:0] OP_STATUS  = 4'hF;

    // The counter value after the last quiet cycle that is still tolerated;
    // one more quiet cycle makes it reach TIMEOUT_CYCLES and aborts.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  PULSE_LAST   = 4'(RST_PULSE_CYCLES - 1);

    state_t      state;
    logic [3:0]  op;
    logic [15:0] to_cnt;
    logic [3:0]  pulse_cnt;

    logic [3:0]  cmd_op;
    logic        cmd_is_write;
    logic        cmd_is_read;
    logic        to_expire;

    always_comb begin
        cmd_op       = rx_byte[3:0];
        cmd_is_write = (cmd_op == OP_RESET) || (cmd_op == OP_MODE_WR) ||
                       (cmd_op == OP_GPIO_WR);
        cmd_is_read  = (cmd_op == OP_MODE_RD) || (cmd_op == OP_GPIO_RD) ||
                       (cmd_op == OP_STATUS);
        to_expire    = (to_cnt == TIMEOUT_LAST);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op        <= OP_RESET;
            to_cnt    <= '0;
            pulse_cnt <= '0;
            mode      <= MODE_RESET;
            gpio_out  <= GPIO_RESET;
            tx_byte   <= 8'h00;
            tx_load   <= 1'b0;
            soft_rst  <= 1'b0;
            err       <= 1'b0;
        end else begin
            tx_load <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (!rx_byte[7]) begin
                            // Data byte with no command in front of it.
                            err <= 1'b1;
                        end else if (cmd_is_write) begin
                            state  <= WDATA;
                            op     <= cmd_op;
                            to_cnt <= '0;
                        end else if (cmd_is_read) begin
                            state   <= RDUMMY;
                            to_cnt  <= '0;
                            tx_load <= 1'b1;
                            case (cmd_op)
                                OP_MODE_RD: tx_byte <= mode;
                                OP_GPIO_RD: tx_byte <= gpio_in;
                                default: begin
                                    // STATUS: report the flag and clear it on the
                                    // same edge, so an error raised later is not lost.
                                    tx_byte <= {err, 3'b000, state, 2'b00};
                                    err     <= 1'b0;
                                end
                            endcase
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                WDATA: begin
                    // A byte arriving on the expiry cycle still counts as data.
                    if (rx_valid) begin
                        state <= IDLE;
                        case (op)
                            OP_MODE_WR: mode     <= rx_byte;
                            OP_GPIO_WR: gpio_out <= rx_byte;
                            default: begin
                                if (rx_byte == 8'h00) begin
                                    state     <= SRST;
                                    soft_rst  <= 1'b1;
                                    pulse_cnt <= PULSE_LAST;
                                    mode      <= MODE_RESET;
                                    gpio_out  <= GPIO_RESET;
                                    err       <= 1'b0;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                        endcase
                    end else if (to_expire) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end

                RDUMMY: begin
                    if (rx_valid) begin
                        state <= IDLE;
                    end else if (to_expire) begin
                        state <= IDLE;
                        err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end

                SRST: begin
                    // Received bytes are dropped for the whole pulse.
                    if (pulse_cnt == 4'd0) begin
                        soft_rst <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        pulse_cnt <= pulse_cnt - 4'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    soft_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - directed self-checking bench for spi_cmd_ctrl

module tb_spi_cmd_ctrl;

    localparam int unsigned T_CYC = 1023;
    localparam int unsigned PULSE = 4;

    logic       sys_clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] gpio_in;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] mode;
    logic [7:0] gpio_out;
    logic       soft_rst;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;

    spi_cmd_ctrl #(
        .TIMEOUT_CYCLES   (T_CYC),
        .RST_PULSE_CYCLES (PULSE),
        .MODE_RESET       (8'h00),
        .GPIO_RESET       (8'h00)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .gpio_in  (gpio_in),
        .tx_byte  (tx_byte),
        .tx_load  (tx_load),
        .mode     (mode),
        .gpio_out (gpio_out),
        .soft_rst (soft_rst),
        .busy     (busy),
        .err      (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Called at a negedge; presents the byte for one posedge and returns at
    // the following negedge, where the effect of that edge is visible.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge sys_clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic test_reset;
        send_byte(8'h8B);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (mode !== 8'h00) begin errors++; $display("FAIL rst_mode got %h exp 00", mode); end
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL rst_gpio got %h exp 00", gpio_out); end
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL rst_tx_byte got %h exp 00", tx_byte); end
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL rst_tx_load got %b exp 0", tx_load); end
        checks++; if (soft_rst !== 1'b0) begin errors++; $display("FAIL rst_soft_rst got %b exp 0", soft_rst); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        @(negedge sys_clk);
        rst = 1'b0;
        send_byte(8'h8B);
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL rst_gpio_early got %h exp 00", gpio_out); end
        send_byte(8'h55);
        checks++; if (gpio_out !== 8'h55) begin errors++; $display("FAIL rst_gpio_write got %h exp 55", gpio_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_post_busy got %b exp 0", busy); end
    endtask

    task automatic test_gpio;
        send_byte(8'h9B);
        send_byte(8'hAA);
        checks++; if (gpio_out !== 8'hAA) begin errors++; $display("FAIL gpio_write got %h exp aa", gpio_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL gpio_write_err got %b exp 0", err); end
        gpio_in = 8'h3C;
        send_byte(8'h8C);
        gpio_in = 8'hFF;
        checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL gpio_rd_load got %b exp 1", tx_load); end
        checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL gpio_rd_byte got %h exp 3c", tx_byte); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gpio_rd_busy got %b exp 1", busy); end
        @(negedge sys_clk);
        checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL gpio_rd_load_width got %b exp 0", tx_load); end
        checks++; if (tx_byte !== 8'h3C) begin errors++; $display("FAIL gpio_rd_hold got %h exp 3c", tx_byte); end
        send_byte(8'h00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gpio_dummy_busy got %b exp 0", busy); end
        checks++; if (gpio_out !== 8'hAA) begin errors++; $display("FAIL gpio_dummy_keep got %h exp aa", gpio_out); end
    endtask

    task automatic test_mode;
        send_byte(8'h81);
        send_byte(8'h08);
        checks++; if (mode !== 8'h08) begin errors++; $display("FAIL mode_write got %h exp 08", mode); end
        send_byte(8'h82);
        checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL mode_rd_load got %b exp 1", tx_load); end
        checks++; if (tx_byte !== 8'h08) begin errors++; $display("FAIL mode_rd_byte got %h exp 08", tx_byte); end
        send_byte(8'h00);
        send_byte(8'h82);
        idle_cycles(T_CYC - 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mode_to_before_busy got %b exp 1", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mode_to_before_err got %b exp 0", err); end
        @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode_to_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL mode_to_err got %b exp 1", err); end
    endtask

    task automatic test_soft_reset;
        int high_cnt;
        send_byte(8'h81);
        send_byte(8'h08);
        send_byte(8'h9B);
        send_byte(8'hAA);
        checks++; if ({mode, gpio_out} !== 16'h08AA) begin errors++; $display("FAIL srst_setup got %h exp 08aa", {mode, gpio_out}); end
        send_byte(8'h80);
        send_byte(8'h00);
        checks++; if (mode !== 8'h00) begin errors++; $display("FAIL srst_mode got %h exp 00", mode); end
        checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL srst_gpio got %h exp 00", gpio_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL srst_err got %b exp 0", err); end
        high_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (soft_rst === 1'b1) high_cnt++;
            if (i == 1) begin
                rx_valid = 1'b1;
                rx_byte  = 8'h8B;
            end
            @(negedge sys_clk);
            rx_valid = 1'b0;
        end
        checks++; if (high_cnt != PULSE) begin errors++; $display("FAIL srst_pulse_len got %0d exp %0d", high_cnt, PULSE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srst_ignored_byte busy got %b exp 0", busy); end
        send_byte(8'h80);
        send_byte(8'h01);
        checks++; if (soft_rst !== 1'b0) begin errors++; $display("FAIL srst_bad_pulse got %b exp 0", soft_rst); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL srst_bad_err got %b exp 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL srst_bad_busy got %b exp 0", busy); end
    endtask

    task automatic test_status;
        send_byte(8'h8F);
        send_byte(8'h00);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_pre_clear got %b exp 0", err); end
        send_byte(8'h85);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL status_badop_err got %b exp 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL status_badop_busy got %b exp 0", busy); end
        send_byte(8'h8F);
        checks++; if (tx_load !== 1'b1) begin errors++; $display("FAIL status_load got %b exp 1", tx_load); end
        checks++; if (tx_byte !== 8'h80) begin errors++; $display("FAIL status_byte1 got %h exp 80", tx_byte); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_clear got %b exp 0", err); end
        send_byte(8'h00);
        send_byte(8'h8F);
        checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL status_byte2 got %h exp 00", tx_byte); end
        send_byte(8'h00);
        send_byte(8'h12);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL status_noncmd_err got %b exp 1", err); end
        send_byte(8'h8F);
        send_byte(8'h00);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL status_reclear got %b exp 0", err); end
    endtask

    task automatic test_timeout_boundary;
        send_byte(8'h8B);
        idle_cycles(T_CYC - 1);
        send_byte(8'h5A);
        checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL tob_limit_gpio got %h exp 5a", gpio_out); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL tob_limit_err got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tob_limit_busy got %b exp 0", busy); end
        send_byte(8'h8B);
        idle_cycles(T_CYC);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tob_expired_err got %b exp 1", err); end
        send_byte(8'h33);
        checks++; if (gpio_out !== 8'h5A) begin errors++; $display("FAIL tob_late_gpio got %h exp 5a", gpio_out); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL tob_late_err got %b exp 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tob_late_busy got %b exp 0", busy); end
        send_byte(8'h8F);
        send_byte(8'h00);
    endtask

    task automatic test_back_to_back;
        send_byte(8'h81);
        send_byte(8'h11);
        send_byte(8'h9B);
        send_byte(8'h22);
        checks++; if (mode !== 8'h11) begin errors++; $display("FAIL b2b_mode got %h exp 11", mode); end
        checks++; if (gpio_out !== 8'h22) begin errors++; $display("FAIL b2b_gpio got %h exp 22", gpio_out); end
        send_byte(8'h82);
        checks++; if (tx_byte !== 8'h11) begin errors++; $display("FAIL b2b_rd got %h exp 11", tx_byte); end
        send_byte(8'hFF);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_dummy_busy got %b exp 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", err); end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        gpio_in  = 8'h00;
        idle_cycles(3);
        rst = 1'b0;
        @(negedge sys_clk);
        test_reset();
        test_gpio();
        test_mode();
        test_soft_reset();
        test_status();
        test_timeout_boundary();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind the SPI byte shifter in sbasu3_top. It consumes received bytes as command/data pairs and decodes the opcode. It owns the MODE and GPIO-out registers, generates the soft-reset pulse, and loads response bytes into the shifter for reads. A data-phase timeout and a sticky error flag recover the block from malformed or truncated transactions.

Parameters:
TIMEOUT_CYCLES, 1023, sys_clk cycles allowed between command byte and its data/dummy byte; range 1..65535
RST_PULSE_CYCLES, 4, length of soft_rst pulse in sys_clk cycles; range 1..15
MODE_RESET, 8'h00, value of mode after rst or soft reset
GPIO_RESET, 8'h00, value of gpio_out after rst or soft reset

Ports:
sys_clk  in  1  system clock, all logic on posedge
rst  in  1  asynchronous, active-high reset
rx_valid  in  1  one-cycle pulse, rx_byte holds a complete received byte (already synchronised to sys_clk)
rx_byte  in  8  received byte
gpio_in  in  8  sampled GPIO inputs
tx_byte  out  8  response byte for shifter
tx_load  out  1  one-cycle pulse: shifter loads tx_byte
mode  out  8  mode register
gpio_out  out  8  GPIO output register
soft_rst  out  1  soft-reset pulse to rest of design
busy  out  1  high when state != IDLE or soft_rst high
err  out  1  sticky error flag

Behaviour:
- rst asserted (async): state=IDLE, mode=MODE_RESET, gpio_out=GPIO_RESET, tx_byte=0, tx_load=0, soft_rst=0, err=0, busy=0, timeout counter=0.
- Command byte: rx_byte[7]=1 in IDLE; opcode = rx_byte[3:0]; bits[6:4] ignored. rx_byte[7]=0 in IDLE: discarded, err set.
- Opcodes: 0x0 RESET (write, data must be 8'h00); 0x1 MODE write; 0x2 MODE read; 0xB GPIO write; 0xC GPIO read; 0xF STATUS read. Any other opcode: err set, stay IDLE.
- States: IDLE, WDATA (write cmd held, awaiting data), RDUMMY (response loaded, awaiting dummy byte), SRST (soft_rst driving).
- IDLE + write cmd -> WDATA, opcode latched, counter cleared.
- IDLE + read cmd -> RDUMMY. Next cycle tx_load=1 for exactly 1 cycle with tx_byte = mode (0x2), gpio_in sampled at the cmd cycle (0xC), or {err, 3'b0, state-at-cmd[1:0]=00, 2'b0} (0xF). A STATUS read clears err in the same cycle tx_byte captures it.
- WDATA + rx_valid: any byte value is data, bit7 not interpreted. Register updates on the cycle after rx_valid. MODE -> mode=byte; GPIO -> gpio_out=byte; RESET with byte 8'h00 -> SRST; RESET with nonzero byte -> err set, no reset. All return to IDLE except RESET-ok.
- RDUMMY + rx_valid: byte discarded -> IDLE.
- Timeout: in WDATA/RDUMMY the counter increments each cycle without rx_valid. When it reaches TIMEOUT_CYCLES: -> IDLE, err set, no register write. rx_valid in the same cycle the limit is reached wins: byte processed normally, no err.
- SRST: soft_rst=1 for exactly RST_PULSE_CYCLES cycles, starting the cycle after the data byte. On entry mode=MODE_RESET, gpio_out=GPIO_RESET, err=0. rx_valid is ignored throughout. Then -> IDLE.
- busy = (state!=IDLE). tx_load is never high outside the cycle after a read command.
- rst during any state aborts immediately to the reset values. No partial writes are ever visible.

Test Plan:
- Reset: assert rst mid-WDATA -> all outputs at reset values, state IDLE, next 0x8B,0x55 sets gpio_out=0x55 one cycle after second rx_valid.
- GPIO write/read: bytes 0x9B,0xAA -> gpio_out=0xAA; with gpio_in=0x3C, bytes 0x8C,0x00 -> tx_load pulse 1 cycle after 0x8C with tx_byte=0x3C.
- MODE write/read: 0x81,0x08 -> mode=0x08; 0x82 -> tx_byte=0x08; 0x82 with no follow-up for TIMEOUT_CYCLES -> IDLE, err=1.
- Soft reset: mode=0x08, gpio_out=0xAA, then 0x80,0x00 -> soft_rst high exactly 4 cycles, mode=0x00, gpio_out=0x00, err=0; byte 0x8B injected during the pulse is ignored. 0x80,0x01 -> no pulse, err=1.
- Errors and status: 0x85 -> err=1, state IDLE; 0x8F -> tx_byte=0x80 and err cleared; following 0x8F -> tx_byte=0x00.
- Timeout boundary: 0x8B then data rx_valid exactly at cycle TIMEOUT_CYCLES -> gpio_out updated, err=0; at TIMEOUT_CYCLES+1 -> err=1, byte treated as IDLE non-command (err stays 1, gpio_out unchanged).
